sort_job_scheduler: RTL and testbench
=====================================

// Module: sort_job_scheduler
// PURPOSE
//  Shares one fsm_sort engine among R requesters. Round-robin arbitration picks a job,
//  latches its N-element vector, pulses sort_start and waits for sort_done. It returns
//  the sorted vector to the owning requester with a valid/ready handshake. A watchdog
//  aborts jobs the engine never completes. Sits between client FSMs and the sorter.
// PARAMETERS
//  R        4     number of requesters (>=2)
//  N        6     elements per job (matches sorter N)
//  WIDTH    8     bits per element
//  TIMEOUT  256   max WAIT cycles before abort (>= N*N+4)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           synchronous reset, active-low
//  req          in   R           requester r has a job pending; held until gnt[r]
//  req_data     in   R x N x W   job vectors, sampled the cycle gnt[r]=1
//  gnt          out  R           one-hot, 1-cycle pulse: job accepted
//  resp_valid   out  R           one-hot: result for requester r on resp_data
//  resp_ready   in   R           requester accepts result
//  resp_data    out  N x W       sorted vector (zeros on abort)
//  resp_err     out  1           qualifies resp_valid: 1 = job aborted by watchdog
//  sort_start   out  1           1-cycle start pulse to sorter
//  sort_data    out  N x W       latched job vector, stable from start until done
//  sort_done    in   1           sorter completion (level)
//  sort_result  in   N x W       sorter output, valid while sort_done=1
//  busy         out  1           1 in any state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, all outputs 0, latches cleared.
//    Reset mid-job drops the job silently. No gnt or resp follows for it.
//  FSM IDLE -> START -> WAIT -> RESP -> IDLE.
//   IDLE : if |req, pick the first set bit at or after rr_ptr (wrapping R-1 -> 0).
//          Pulse gnt[w] and latch req_data[w] into sort_data and owner=w. Go to START.
//   START: sort_start=1 for exactly this cycle; clear watchdog. Go to WAIT.
//   WAIT : ignore sort_done in the first WAIT cycle, so a stale done from a previous
//          job is not taken as completion.
//          From the 2nd cycle on, sort_done=1 latches sort_result into resp_data,
//          sets resp_err=0 and goes to RESP.
//          If the watchdog reaches TIMEOUT first: resp_data=0, resp_err=1, go to RESP.
//   RESP : resp_valid[owner]=1; resp_data and resp_err held stable. On resp_ready[owner],
//          set rr_ptr=(owner+1) mod R and go to IDLE. resp_ready of other bits is ignored.
//  Latency: gnt to sort_start is 1 cycle. sort_done to resp_valid is 1 cycle.
//    Best-case back-to-back gnt spacing is sorter latency + 4 cycles.
//  A requester may drop req before gnt; this is a withdrawal, with no side effects.
//  req[owner] reasserted during the job is treated as a new job and arbitrated normally.
//  When req and resp_ready of the same requester rise together, RESP->IDLE takes priority.
//    The new req is seen in IDLE on the next cycle.
//  Only one job is in flight. gnt, resp_valid and sort_start are never asserted together.
//  rr_ptr is $clog2(R) bits with explicit wrap for non-power-of-2 R.
//    The watchdog is $clog2(TIMEOUT+1) bits and saturates.
// STRUCTURE
//  sort_pkg: sched_state_e {IDLE,START,WAIT,RESP}, and the vec_t typedef (N x WIDTH
//    unpacked). Shared with fsm_sort and the benches.
//  Sub-module rr_arbiter #(R): req, ptr -> one-hot grant and grant index (combinational).
//  Top holds FSM, job/result latches, owner register, rr_ptr and watchdog.
// TESTING
//  T1 single job: req=0001, data {5,0,2,1,1,3} -> gnt=0001 1 cycle; one sort_start;
//     resp_valid[0] with {0,1,1,2,3,5}, err=0.
//  T2 fairness: req=1111 held, each job re-requested after its resp ->
//     grant order 0,1,2,3,0,1; no requester starved.
//  T3 backpressure: resp_ready[2]=0 for 10 cycles -> resp_valid/resp_data stable;
//     no gnt issued; release -> IDLE.
//  T4 timeout: sorter model never asserts done, TIMEOUT=40 ->
//     resp_valid[owner], err=1, data=0, 42 cycles after start.
//  T5 reset mid-WAIT: rst_n=0 one cycle -> all outputs 0 next edge; prior owner
//     gets no resp; new req served normally.
//  T6 stale done: sort_done stuck high across jobs, all-equal input {1,1,1,1,1,1} ->
//     completion accepted only from the 2nd WAIT cycle; result {1,1,1,1,1,1}.

Source files
------------

// File: rtl/sort_job_scheduler_pkg.sv
// Shared types for the sort job scheduler and its clients.
// Default sizes match the fsm_sort engine.
package sort_job_scheduler_pkg;

  localparam int R_DEF       = 4;
  localparam int N_DEF       = 6;
  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } sched_state_e;

  typedef logic [W_DEF-1:0] vec_t [N_DEF];

endpackage

// File: rtl/sort_job_scheduler_if.sv
// Requester and sorter signals of the sort job scheduler.
// master = scheduler side, slave = clients plus sorter.
interface sort_job_scheduler_if
  import sort_job_scheduler_pkg::*;
#(
  parameter int R = R_DEF,
  parameter int N = N_DEF,
  parameter int W = W_DEF
);

  logic [R-1:0]                 req;
  logic [R-1:0][N-1:0][W-1:0]   req_data;
  logic [R-1:0]                 gnt;
  logic [R-1:0]                 resp_valid;
  logic [R-1:0]                 resp_ready;
  logic [N-1:0][W-1:0]          resp_data;
  logic                         resp_err;
  logic                         sort_start;
  logic [N-1:0][W-1:0]          sort_data;
  logic                         sort_done;
  logic [N-1:0][W-1:0]          sort_result;
  logic                         busy;

  modport master (
    input  req, req_data, resp_ready,
    input  sort_done, sort_result,
    output gnt, resp_valid, resp_data,
    output resp_err, sort_start, sort_data,
    output busy
  );

  modport slave (
    output req, req_data, resp_ready,
    output sort_done, sort_result,
    input  gnt, resp_valid, resp_data,
    input  resp_err, sort_start, sort_data,
    input  busy
  );

endinterface

// File: rtl/sort_job_scheduler_rr_arbiter.sv
// Round-robin pick: first request at or after ptr,
// wrapping R-1 -> 0. Purely combinational.
module sort_job_scheduler_rr_arbiter #(
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = R - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= R) k = k - R;
      if (req[k[IW-1:0]]) begin
        idx = k[IW-1:0];
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sort_job_scheduler.sv
// Shares one sort engine among R requesters: round-robin
// grant, start pulse, watchdog-guarded wait, result handshake.
module sort_job_scheduler
  import sort_job_scheduler_pkg::*;
#(
  parameter int R       = R_DEF,
  parameter int N       = N_DEF,
  parameter int WIDTH   = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  sort_job_scheduler_if.master bus
);

  localparam int IW  = (R > 1) ? $clog2(R) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  sched_state_e   state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  owner;
  logic [WDW-1:0] wd;

  logic [R-1:0]   arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;

  sort_job_scheduler_rr_arbiter #(
    .R  (R),
    .IW (IW)
  ) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Grant is shown in the IDLE cycle whose edge latches the job.
  assign bus.gnt = (state == IDLE && rst_n) ? arb_gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      wd             <= '0;
      bus.sort_start <= 1'b0;
      bus.sort_data  <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.sort_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            bus.sort_data  <= bus.req_data[arb_idx];
            owner          <= arb_idx;
            bus.sort_start <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // wd==0 marks the first WAIT cycle: a done here is stale.
          if (wd != '0 && bus.sort_done) begin
            bus.resp_data  <= bus.sort_result;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= R'(1) << owner;
            state          <= RESP;
          end else if (wd == WDW'(TIMEOUT)) begin
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= R'(1) << owner;
            state          <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready[owner]) begin
            bus.resp_valid <= '0;
            bus.busy       <= 1'b0;
            rr_ptr         <= (owner == IW'(R - 1)) ?
                              '0 : owner + 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Self-checking bench for sort_job_scheduler with a
// behavioural sorter model and a round-robin reference.
module tb_sort_job_scheduler;
  import sort_job_scheduler_pkg::*;

  localparam int R  = 4;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int TO = 40;

  typedef logic [N-1:0][W-1:0] pvec_t;

  typedef struct {
    logic [R-1:0] mask;
    pvec_t        data;
    logic [R-1:0] eg;
    pvec_t        ed;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_job_scheduler_if #(.R(R), .N(N), .W(W)) bus();

  sort_job_scheduler #(
    .R       (R),
    .N       (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  // sorter model: 0 normal, 1 never done, 2 done stuck high
  int smode = 0;
  int slat  = 1;
  bit pend;
  int cnt;

  function automatic pvec_t sort_vec(input pvec_t v);
    logic [W-1:0] q[$];
    pvec_t r;
    for (int i = 0; i < N; i++) q.push_back(v[i]);
    q.sort();
    for (int i = 0; i < N; i++) r[i] = q[i];
    return r;
  endfunction

  function automatic pvec_t mk(input int a, b, c,
                               input int d, e, f);
    pvec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c);
    v[3] = W'(d); v[4] = W'(e); v[5] = W'(f);
    return v;
  endfunction

  function automatic pvec_t rnd_vec();
    pvec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.sort_done   <= 1'b0;
      bus.sort_result <= '0;
      pend            <= 1'b0;
      cnt             <= 0;
    end else begin
      if (bus.sort_start) begin
        pend <= 1'b1;
        cnt  <= slat;
        if (smode != 2) bus.sort_done <= 1'b0;
      end else if (pend && smode != 1) begin
        if (cnt <= 1) begin
          bus.sort_result <= sort_vec(bus.sort_data);
          bus.sort_done   <= 1'b1;
          pend            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (smode == 2) bus.sort_done <= 1'b1;
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic do_reset();
    bus.req        = '0;
    bus.resp_ready = '0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Entered and left at posedge+1; one full job with checks.
  task automatic serve(input string nm,
                       input logic [R-1:0] mask,
                       input pvec_t lanes [R],
                       input logic [R-1:0] eg,
                       input pvec_t ed,
                       input logic eerr,
                       input int elat,
                       input int rdly);
    logic [R-1:0] g;
    int lat;
    bit ok;
    pvec_t hd;
    bus.req = mask;
    for (int i = 0; i < R; i++) bus.req_data[i] = lanes[i];
    bus.resp_ready = '0;
    g = '0;
    for (int c = 0; c < 20 && g == '0; c++) begin
      @(negedge clk);
      g = bus.gnt;
    end
    check({nm, " gnt"}, 64'(g), 64'(eg));
    if (g == '0) begin
      bus.req = '0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    bus.req = bus.req & ~g;
    @(negedge clk);
    check({nm, " start"},
          64'({bus.sort_start, bus.gnt, bus.resp_valid}),
          64'({1'b1, {R{1'b0}}, {R{1'b0}}}));
    lat = 0;
    for (int c = 1; c <= TO + 10 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) lat = c;
    end
    check({nm, " lat"}, 64'(lat), 64'(elat));
    check({nm, " valid"}, 64'(bus.resp_valid), 64'(g));
    check({nm, " data"}, 64'(bus.resp_data), 64'(ed));
    check({nm, " err"}, 64'(bus.resp_err), 64'(eerr));
    hd = bus.resp_data;
    ok = 1'b1;
    for (int d = 0; d < rdly; d++) begin
      @(posedge clk); #1;
      bus.resp_ready = ~g;
      @(negedge clk);
      if (bus.resp_valid != g || bus.resp_data != hd ||
          bus.resp_err != eerr || bus.gnt != '0 ||
          bus.sort_start)
        ok = 1'b0;
    end
    if (rdly > 0) check({nm, " hold"}, 64'(ok), 64'(1));
    @(posedge clk); #1;
    bus.resp_ready = g;
    @(posedge clk); #1;
    bus.resp_ready = '0;
    check({nm, " release"},
          64'({bus.busy, bus.resp_valid}), 64'(0));
  endtask

  vec_rec_t tbl [5];
  pvec_t lanes [R];
  int order [6] = '{0, 1, 2, 3, 0, 1};
  int mptr;
  int w;
  logic [R-1:0] m;

  initial begin
    bus.req         = '0;
    bus.req_data    = '0;
    bus.resp_ready  = '0;

    tbl[0] = '{4'b0001, mk(5, 0, 2, 1, 1, 3),
               4'b0001, mk(0, 1, 1, 2, 3, 5)};
    tbl[1] = '{4'b0001, mk(9, 8, 7, 6, 5, 4),
               4'b0001, mk(4, 5, 6, 7, 8, 9)};
    tbl[2] = '{4'b1001, mk(255, 0, 128, 127, 1, 254),
               4'b1000, mk(0, 1, 127, 128, 254, 255)};
    tbl[3] = '{4'b0110, mk(3, 3, 2, 2, 1, 1),
               4'b0010, mk(1, 1, 2, 2, 3, 3)};
    tbl[4] = '{4'b0011, mk(10, 20, 30, 40, 50, 60),
               4'b0001, mk(10, 20, 30, 40, 50, 60)};

    do_reset();
    @(negedge clk);
    check("reset outs",
          64'({bus.gnt, bus.resp_valid, bus.sort_start,
               bus.busy, bus.resp_err}), 64'(0));
    check("reset data",
          64'(bus.sort_data | bus.resp_data), 64'(0));
    @(posedge clk); #1;

    // table: T1 first, then pointer wrap cases
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < R; i++) begin
        if (tbl[t].eg[i]) lanes[i] = tbl[t].data;
        else lanes[i] = rnd_vec();
      end
      serve($sformatf("tbl%0d", t), tbl[t].mask, lanes,
            tbl[t].eg, tbl[t].ed, 1'b0, 3, t % 2);
    end

    // T2 fairness with all requesters always pending
    do_reset();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < R; i++) lanes[i] = rnd_vec();
      serve($sformatf("fair%0d", j), 4'b1111, lanes,
            4'(1 << order[j]), sort_vec(lanes[order[j]]),
            1'b0, 3, 0);
    end

    // T3 backpressure on requester 2
    for (int i = 0; i < R; i++) lanes[i] = rnd_vec();
    serve("bp", 4'b1111, lanes, 4'b0100,
          sort_vec(lanes[2]), 1'b0, 3, 10);

    // T4 watchdog abort
    smode = 1;
    for (int i = 0; i < R; i++) lanes[i] = rnd_vec();
    serve("timeout", 4'b0001, lanes, 4'b0001,
          '0, 1'b1, TO + 2, 2);
    smode = 0;

    // T5 reset while waiting on the sorter
    smode = 1;
    for (int i = 0; i < R; i++) lanes[i] = rnd_vec();
    bus.req = 4'b0010;
    for (int i = 0; i < R; i++) bus.req_data[i] = lanes[i];
    m = '0;
    for (int c = 0; c < 20 && m == '0; c++) begin
      @(negedge clk);
      m = bus.gnt;
    end
    check("rst gnt", 64'(m), 64'(4'b0010));
    @(posedge clk); #1;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst mid outs",
          64'({bus.gnt, bus.resp_valid, bus.sort_start,
               bus.busy, bus.resp_err}), 64'(0));
    check("rst mid data",
          64'(bus.sort_data | bus.resp_data), 64'(0));
    rst_n = 1'b1;
    smode = 0;
    m = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m = m | bus.resp_valid;
    end
    check("rst no resp", 64'(m), 64'(0));
    @(posedge clk); #1;
    lanes[3] = mk(7, 6, 9, 2, 4, 8);
    serve("after rst", 4'b1000, lanes, 4'b1000,
          mk(2, 4, 6, 7, 8, 9), 1'b0, 3, 0);

    // T6 done stuck high with a stale result present
    smode = 2;
    slat  = 1;
    lanes[0] = mk(1, 1, 1, 1, 1, 1);
    lanes[1] = rnd_vec();
    serve("stale", 4'b0001, lanes, 4'b0001,
          mk(1, 1, 1, 1, 1, 1), 1'b0, 3, 0);
    smode = 0;

    // randomized jobs against the round-robin reference
    do_reset();
    mptr = 0;
    for (int j = 0; j < 30; j++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < R; i++) lanes[i] = rnd_vec();
      w = -1;
      for (int i = 0; i < R && w < 0; i++)
        if (m[(mptr + i) % R]) w = (mptr + i) % R;
      slat = $urandom_range(1, 6);
      serve($sformatf("rnd%0d", j), m, lanes, 4'(1 << w),
            sort_vec(lanes[w]), 1'b0, slat + 2,
            $urandom_range(0, 3));
      mptr = (w + 1) % R;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
